// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared types and constants for the UART transmit scheduler
package uart_tx_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Gray-coded so adjacent frame phases differ by a single state bit
    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_START  = 3'b001,
        ST_DATA   = 3'b011,
        ST_PARITY = 3'b010,
        ST_STOP   = 3'b110
    } state_t;

endpackage

// File: rtl/uart_tx_rr_arb.sv
// rtl/uart_tx_rr_arb.sv - two-way round-robin arbiter, grants only on the accept strobe
module uart_tx_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);

    logic last_q, last_d;

    always_comb begin
        grant_o = 2'b00;
        if (accept_i) begin
            case (valid_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
                default: grant_o = 2'b00;
            endcase
        end
    end

    always_comb begin
        last_d = last_q;
        if (grant_o[0]) begin
            last_d = 1'b0;
        end else if (grant_o[1]) begin
            last_d = 1'b1;
        end
    end

    // Reset to "req1 last" so req0 wins the first contention
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - arbitrated UART frame sequencer driving the shared TX line
module uart_tx_sched
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  TX_TICK,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  req0_valid,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req0_ready,
    output logic                  req1_ready,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_q, tx_d;

    logic                  accept;
    logic [1:0]            grant;
    logic [DATA_WIDTH-1:0] sel_data;

    assign accept     = (state_q == ST_IDLE) && TX_TICK;
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign sel_data   = grant[1] ? req1_data : req0_data;
    assign busy       = (state_q != ST_IDLE);
    assign TX_OUT     = tx_q;

    uart_tx_rr_arb u_arb (
        .clk      (clk),
        .rst      (rst),
        .valid_i  ({req1_valid, req0_valid}),
        .accept_i (accept),
        .grant_o  (grant)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    shift_d   = sel_data;
                    par_en_d  = PAR_EN;
                    par_bit_d = (^sel_data) ^ (PAR_TYP == PAR_ODD);
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (TX_TICK) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end
            end
            ST_DATA: begin
                if (TX_TICK) begin
                    shift_d = shift_q >> 1;
                    if (cnt_q == LAST_BIT) begin
                        cnt_d   = '0;
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (TX_TICK) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (TX_TICK) begin
                    state_d    = ST_IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line level follows the next state so each bit appears on the cycle after its tick
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_bit_d;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
        end
    end

endmodule
